fu_issue_sched: RTL and testbench
=================================

FU_ISSUE_SCHED -- requirements
Module: fu_issue_sched

Interface
REQ-001 Parameter LAT_ADD, default 2, add/sub unit latency in cycles (range 1..15).
REQ-002 Parameter LAT_MUL, default 4, multiply latency in cycles (range 1..15).
REQ-003 Parameter LAT_DIV, default 6, divide latency in cycles (range 1..15).
REQ-004 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 rs_ready  input  4  per reservation-station entry: both operands valid and entry waiting.
REQ-007 rs_func  input  16  4-bit func per entry; entry i is bits [4i+3:4i].
REQ-008 rs_rob  input  12  3-bit ROB index per entry; entry i is bits [3i+2:3i].
REQ-009 issue_valid  output  1  one entry dispatched to a functional unit this cycle.
REQ-010 issue_idx  output  2  index of the dispatched entry.
REQ-011 issue_func  output  4  func of the dispatched entry.
REQ-012 issue_rob  output  3  ROB index of the dispatched entry.
REQ-013 add_busy  output  1  add/sub unit occupied (executing or holding a result).
REQ-014 md_busy  output  1  mul/div unit occupied (executing or holding a result).
REQ-015 cdb_valid  output  1  common data bus broadcast this cycle.
REQ-016 cdb_rob  output  3  ROB index being broadcast.
REQ-017 cdb_unit  output  1  broadcast source: 0 add/sub, 1 mul/div.

Function
REQ-018 Func decode: 0000 and 0001 map to add/sub; 0010 maps to mul/div with LAT_MUL; 0011 maps to mul/div with LAT_DIV; any other func is never issued.
REQ-019 Issue outputs are combinational from the current inputs and state; issue_idx, issue_func and issue_rob are 0 whenever issue_valid is 0.
REQ-020 An entry is eligible when its rs_ready bit is 1, its func is issuable, and its target unit is idle (not busy) in the current cycle.
REQ-021 At most one issue per cycle; the choice among eligible entries follows REQ-036/REQ-037.
REQ-022 Each unit is non-pipelined, with states IDLE -> EXEC -> DONE -> IDLE.
REQ-023 On issue, the target unit enters EXEC, latches the ROB index, and loads its down-counter with the latency.
REQ-024 In EXEC the counter decrements once per cycle; when it reaches 0 the unit enters DONE, so DONE is first reached exactly L cycles after the issue edge.
REQ-025 In DONE the unit requests the CDB; it returns to IDLE on the edge where it is granted.
REQ-026 CDB arbitration: one grant per cycle; if both units are in DONE, mul/div wins and add/sub stays in DONE (retries next cycle).
REQ-027 A unit returning to IDLE is busy until that edge; it is not eligible for issue in its grant cycle (no same-cycle reuse).
REQ-028 add_busy and md_busy are 1 in EXEC and in DONE.
REQ-029 Requester contract: it drops rs_ready for the issued entry on the cycle after issue; the block does not track entry clearing.
REQ-030 Counter and ROB-index registers are 4 bits and 3 bits respectively; there is no overflow path.

Reset
REQ-031 While rst is high at a clk1 edge, both units go to IDLE, counters clear to 0, latched ROB indices clear to 0, and the round-robin pointer clears to 0.
REQ-032 After reset, all outputs are 0: issue_valid, issue_idx, issue_func, issue_rob, add_busy, md_busy, cdb_valid, cdb_rob, cdb_unit.
REQ-033 Reset mid-EXEC or mid-DONE discards the in-flight operation with no CDB broadcast.
REQ-034 Issue outputs are forced to 0 while rst is high.

Configuration
REQ-035 Macro FU_SCHED_RR_EN selects the issue-selection policy.
REQ-036 With FU_SCHED_RR_EN defined: round-robin selection.
- Search starts at pointer p and picks the first eligible entry in order p, p+1, ... mod 4.
- On issue of entry i, the pointer becomes (i+1) mod 4; the pointer wraps 3 -> 0.
REQ-037 With FU_SCHED_RR_EN undefined: fixed priority, lowest index wins; no pointer register is present.

Verification
REQ-038 Reset, then entry 2 ready with func 0000 and ROB 5 -> same cycle issue_valid=1, issue_idx=2, issue_rob=5; cdb_valid=1 with cdb_rob=5 and cdb_unit=0 exactly 2 cycles after the issue edge.
REQ-039 Entries 0 (func 0010, ROB 1) and 1 (func 0011, ROB 2) ready together -> entry 0 issues; entry 1 waits until md_busy falls; CDB broadcasts ROB 1 at +4, then entry 1 issues the next cycle and broadcasts ROB 2 6 cycles later.
REQ-040 Add (ROB 3) issued 2 cycles after a mul (ROB 4) -> both reach DONE together; CDB broadcasts ROB 4 (cdb_unit=1) first, then ROB 3 the next cycle; add_busy stays 1 during the wait.
REQ-041 All 4 entries ready with func 0000, requester dropping each issued entry -> with FU_SCHED_RR_EN, issue order 0,1,2,3 then wrap to 0; without it, index order 0,1,2,3.
REQ-042 rst asserted 1 cycle into a div -> no broadcast, all outputs 0 next cycle; entry with func 0100 ready alone -> issue_valid stays 0.

Source files
------------

// File: rtl/fu_issue_sched.sv
// Issue scheduler for one add/sub unit and one mul/div unit sharing a single CDB.
// Define FU_SCHED_RR_EN for round-robin issue selection; otherwise the lowest index wins.
module fu_issue_sched #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 6
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [3:0]  rs_ready,
    input  logic [15:0] rs_func,
    input  logic [11:0] rs_rob,
    output logic        issue_valid,
    output logic [1:0]  issue_idx,
    output logic [3:0]  issue_func,
    output logic [2:0]  issue_rob,
    output logic        add_busy,
    output logic        md_busy,
    output logic        cdb_valid,
    output logic [2:0]  cdb_rob,
    output logic        cdb_unit
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} unit_state_t;

    // Unit 0 is add/sub, unit 1 is mul/div.
    unit_state_t state_reg [2];
    unit_state_t state_next [2];
    logic [3:0]  cnt_reg [2];
    logic [3:0]  cnt_next [2];
    logic [2:0]  rob_reg [2];
    logic [2:0]  rob_next [2];
    logic [1:0]  unit_issue;
    logic [3:0]  unit_lat [2];
    logic [1:0]  grant;

    logic [3:0] elig;
    logic [1:0] ptr;
    logic       sel_found;
    logic [1:0] sel_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [3:0] func;
            logic       is_add;
            logic       is_md;
            assign func   = rs_func[4*gi +: 4];
            assign is_add = (func[3:1] == 3'b000);
            assign is_md  = (func[3:1] == 3'b001);
            assign elig[gi] = rs_ready[gi] &&
                              ((is_add && state_reg[0] == IDLE) || (is_md && state_reg[1] == IDLE));
        end
    endgenerate

    always_comb begin
        logic [1:0] cand;
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        issue_valid = sel_found && !rst;
        issue_idx   = 2'd0;
        issue_func  = 4'd0;
        issue_rob   = 3'd0;
        if (issue_valid) begin
            issue_idx  = sel_idx;
            issue_func = rs_func[4*sel_idx +: 4];
            issue_rob  = rs_rob[3*sel_idx +: 3];
        end
    end

`ifdef FU_SCHED_RR_EN
    logic [1:0] ptr_reg;
    always_ff @(posedge clk1) begin
        if (rst)
            ptr_reg <= 2'd0;
        else if (issue_valid)
            ptr_reg <= issue_idx + 2'd1;
    end
    assign ptr = ptr_reg;
`else
    assign ptr = 2'd0;
`endif

    assign unit_issue[0] = issue_valid && (issue_func[3:1] == 3'b000);
    assign unit_issue[1] = issue_valid && (issue_func[3:1] == 3'b001);
    assign unit_lat[0]   = 4'(LAT_ADD);
    assign unit_lat[1]   = issue_func[0] ? 4'(LAT_DIV) : 4'(LAT_MUL);

    // Mul/div has CDB priority; a losing add/sub result simply stays in DONE.
    assign grant[1] = (state_reg[1] == DONE);
    assign grant[0] = (state_reg[0] == DONE) && (state_reg[1] != DONE);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit
            always_ff @(posedge clk1) begin
                if (rst) begin
                    state_reg[gi] <= IDLE;
                    cnt_reg[gi]   <= 4'd0;
                    rob_reg[gi]   <= 3'd0;
                end else begin
                    state_reg[gi] <= state_next[gi];
                    cnt_reg[gi]   <= cnt_next[gi];
                    rob_reg[gi]   <= rob_next[gi];
                end
            end

            always_comb begin
                state_next[gi] = state_reg[gi];
                cnt_next[gi]   = cnt_reg[gi];
                rob_next[gi]   = rob_reg[gi];
                case (state_reg[gi])
                    IDLE: if (unit_issue[gi]) begin
                        state_next[gi] = EXEC;
                        cnt_next[gi]   = unit_lat[gi];
                        rob_next[gi]   = issue_rob;
                    end
                    EXEC: begin
                        cnt_next[gi] = cnt_reg[gi] - 4'd1;
                        if (cnt_reg[gi] <= 4'd1) begin
                            state_next[gi] = DONE;
                            cnt_next[gi]   = 4'd0;
                        end
                    end
                    DONE: if (grant[gi]) state_next[gi] = IDLE;
                    default: state_next[gi] = IDLE;
                endcase
            end
        end
    endgenerate

    assign add_busy  = (state_reg[0] != IDLE);
    assign md_busy   = (state_reg[1] != IDLE);
    assign cdb_valid = grant[0] | grant[1];
    assign cdb_unit  = grant[1];
    assign cdb_rob   = grant[1] ? rob_reg[1] : (grant[0] ? rob_reg[0] : 3'd0);
endmodule

// File: tb/tb_fu_issue_sched.sv
// Scoreboard bench for fu_issue_sched: stimulus queues expected issue/CDB events
// tagged with their cycle, and a negedge monitor pops and compares them.
module tb_fu_issue_sched;
    logic        clk1;
    logic        rst;
    logic [3:0]  rs_ready;
    logic [15:0] rs_func;
    logic [11:0] rs_rob;
    logic        issue_valid;
    logic [1:0]  issue_idx;
    logic [3:0]  issue_func;
    logic [2:0]  issue_rob;
    logic        add_busy;
    logic        md_busy;
    logic        cdb_valid;
    logic [2:0]  cdb_rob;
    logic        cdb_unit;

    fu_issue_sched dut (
        .clk1(clk1), .rst(rst), .rs_ready(rs_ready), .rs_func(rs_func), .rs_rob(rs_rob),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_func(issue_func),
        .issue_rob(issue_rob), .add_busy(add_busy), .md_busy(md_busy),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_unit(cdb_unit)
    );

    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic [3:0] func;
        logic [2:0] rob;
    } iss_t;
    typedef struct {
        int         cyc;
        logic [2:0] rob;
        logic       unit;
    } cdb_t;

    iss_t iss_q [$];
    cdb_t cdb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;

    initial begin
        clk1 = 0;
        forever #5 clk1 = ~clk1;
    end

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_ent(input int i, input logic [3:0] f, input logic [2:0] r);
        rs_func[4*i +: 4] = f;
        rs_rob[3*i +: 3]  = r;
    endtask

    task automatic push_iss(input int c, input logic [1:0] i, input logic [3:0] f, input logic [2:0] r);
        iss_t e;
        e.cyc = c; e.idx = i; e.func = f; e.rob = r;
        iss_q.push_back(e);
    endtask

    task automatic push_cdb(input int c, input logic [2:0] r, input logic u);
        cdb_t e;
        e.cyc = c; e.rob = r; e.unit = u;
        cdb_q.push_back(e);
    endtask

    always @(negedge clk1) begin
        if (mon_en) begin
            if (issue_valid !== 1'b0) begin
                n_tests++;
                if (iss_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL issue: unexpected issue idx=%0d func=%0h rob=%0d at cycle %0d",
                             issue_idx, issue_func, issue_rob, cyc);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    if (e.cyc != cyc || issue_idx !== e.idx || issue_func !== e.func || issue_rob !== e.rob) begin
                        n_fail++;
                        $display("[TB] FAIL issue: got cyc=%0d idx=%0d func=%0h rob=%0d expected cyc=%0d idx=%0d func=%0h rob=%0d",
                                 cyc, issue_idx, issue_func, issue_rob, e.cyc, e.idx, e.func, e.rob);
                    end else
                        $display("[TB] issue idx=%0d func=%0h rob=%0d cycle %0d ok", issue_idx, issue_func, issue_rob, cyc);
                end
            end else begin
                n_tests++;
                if ({issue_idx, issue_func, issue_rob} !== 9'd0) begin
                    n_fail++;
                    $display("[TB] FAIL issue_idle: got idx=%0d func=%0h rob=%0d expected all 0",
                             issue_idx, issue_func, issue_rob);
                end
            end
            if (cdb_valid !== 1'b0) begin
                n_tests++;
                if (cdb_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL cdb: unexpected broadcast rob=%0d unit=%0d at cycle %0d", cdb_rob, cdb_unit, cyc);
                end else begin
                    cdb_t e;
                    e = cdb_q.pop_front();
                    if (e.cyc != cyc || cdb_rob !== e.rob || cdb_unit !== e.unit) begin
                        n_fail++;
                        $display("[TB] FAIL cdb: got cyc=%0d rob=%0d unit=%0d expected cyc=%0d rob=%0d unit=%0d",
                                 cyc, cdb_rob, cdb_unit, e.cyc, e.rob, e.unit);
                    end else
                        $display("[TB] cdb rob=%0d unit=%0d cycle %0d ok", cdb_rob, cdb_unit, cyc);
                end
            end
        end
    end

    logic [3:0] slot_mask [7];
    logic [1:0] slot_ord  [7];

    initial begin
        int c;
        rst = 1; rs_ready = '0; rs_func = '0; rs_rob = '0;
        repeat (3) step();
        rst = 0;
        #1;
        chk("reset_issue_valid", 32'(issue_valid), 0);
        chk("reset_issue_idx", 32'(issue_idx), 0);
        chk("reset_issue_func", 32'(issue_func), 0);
        chk("reset_issue_rob", 32'(issue_rob), 0);
        chk("reset_add_busy", 32'(add_busy), 0);
        chk("reset_md_busy", 32'(md_busy), 0);
        chk("reset_cdb_valid", 32'(cdb_valid), 0);
        chk("reset_cdb_rob", 32'(cdb_rob), 0);
        chk("reset_cdb_unit", 32'(cdb_unit), 0);
        mon_en = 1;

        // Single add on entry 2: result on the CDB two cycles after the issue edge.
        step();
        c = cyc;
        set_ent(2, 4'h0, 3'd5); rs_ready = 4'b0100;
        push_iss(c, 2'd2, 4'h0, 3'd5);
        push_cdb(c + 3, 3'd5, 1'b0);
        step(); rs_ready = 4'b0000;
        chk("t1_add_busy", 32'(add_busy), 1);
        repeat (5) step();
        chk("t1_add_idle", 32'(add_busy), 0);

        // Mul then div contending for the mul/div unit.
        c = cyc;
        set_ent(0, 4'h2, 3'd1); set_ent(1, 4'h3, 3'd2); rs_ready = 4'b0011;
        push_iss(c, 2'd0, 4'h2, 3'd1);
        push_cdb(c + 5, 3'd1, 1'b1);
        push_iss(c + 6, 2'd1, 4'h3, 3'd2);
        push_cdb(c + 13, 3'd2, 1'b1);
        step(); rs_ready = 4'b0010;
        chk("t2_md_busy", 32'(md_busy), 1);
        repeat (5) step();
        step(); rs_ready = 4'b0000;
        repeat (8) step();
        chk("t2_md_idle", 32'(md_busy), 0);

        // Mul and add finishing together: mul/div wins the CDB, add waits a cycle.
        c = cyc;
        set_ent(0, 4'h2, 3'd4); rs_ready = 4'b0001;
        push_iss(c, 2'd0, 4'h2, 3'd4);
        push_cdb(c + 5, 3'd4, 1'b1);
        step(); rs_ready = 4'b0000;
        step();
        set_ent(1, 4'h0, 3'd3); rs_ready = 4'b0010;
        push_iss(c + 2, 2'd1, 4'h0, 3'd3);
        push_cdb(c + 6, 3'd3, 1'b0);
        step(); rs_ready = 4'b0000;
        step();
        step(); chk("t3_add_busy_wait", 32'(add_busy), 1);
        step(); chk("t3_add_busy_grant", 32'(add_busy), 1);
        step(); chk("t3_add_idle", 32'(add_busy), 0);
        chk("t3_md_idle", 32'(md_busy), 0);

        // Four add entries, then re-raised entries to expose the selection policy.
        for (int i = 0; i < 4; i++) set_ent(i, 4'h0, 3'(i + 4));
        slot_mask[0] = 4'b1111; slot_mask[1] = 4'b0000; slot_mask[2] = 4'b0000;
        slot_mask[3] = 4'b0000; slot_mask[4] = 4'b0001; slot_mask[5] = 4'b1001;
        slot_mask[6] = 4'b0000;
        slot_ord[0] = 2'd0; slot_ord[1] = 2'd1; slot_ord[2] = 2'd2; slot_ord[3] = 2'd3;
        slot_ord[4] = 2'd0;
`ifdef FU_SCHED_RR_EN
        slot_ord[5] = 2'd3; slot_ord[6] = 2'd0;
`else
        slot_ord[5] = 2'd0; slot_ord[6] = 2'd3;
`endif
        for (int k = 0; k < 7; k++) begin
            c = cyc;
            rs_ready = rs_ready | slot_mask[k];
            push_iss(c, slot_ord[k], 4'h0, 3'(slot_ord[k] + 4));
            push_cdb(c + 3, 3'(slot_ord[k] + 4), 1'b0);
            step();
            rs_ready[slot_ord[k]] = 1'b0;
            repeat (3) step();
        end
        chk("t4_ready_drained", 32'(rs_ready), 0);

        // Reset one cycle into a divide, then an unissuable func.
        c = cyc;
        set_ent(0, 4'h3, 3'd6); rs_ready = 4'b0001;
        push_iss(c, 2'd0, 4'h3, 3'd6);
        step(); rs_ready = 4'b0000;
        chk("t5_md_busy", 32'(md_busy), 1);
        step();
        rst = 1; set_ent(1, 4'h0, 3'd1); rs_ready = 4'b0010;
        #1 chk("t5_issue_forced_0", 32'(issue_valid), 0);
        step();
        rst = 0; rs_ready = 4'b0000;
        #1;
        chk("t5_post_rst_issue", {23'd0, issue_valid, issue_idx, issue_func, issue_rob}, 0);
        chk("t5_post_rst_busy", {30'd0, add_busy, md_busy}, 0);
        chk("t5_post_rst_cdb", {27'd0, cdb_valid, cdb_rob, cdb_unit}, 0);
        repeat (8) step();
        set_ent(3, 4'h4, 3'd7); rs_ready = 4'b1000;
        #1 chk("t5_func4_not_issued", 32'(issue_valid), 0);
        repeat (3) step();
        chk("t5_func4_units_idle", {30'd0, add_busy, md_busy}, 0);
        rs_ready = 4'b0000;
        repeat (2) step();

        chk("issue_queue_drained", iss_q.size(), 0);
        chk("cdb_queue_drained", cdb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
